// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: mode encodings,
// default widths, counter direction type and a period-length helper.
package pwm_pkg;

  // Counting modes as presented on mode_shdw.
  localparam logic PWM_EDGE   = 1'b0;
  localparam logic PWM_CENTER = 1'b1;

  // Default geometry.
  localparam int unsigned PWM_CH_COUNT_DEF   = 4;
  localparam int unsigned PWM_CNT_WIDTH_DEF  = 8;
  localparam int unsigned PWM_PERIOD_RST_DEF = 255;

  // Counter direction; only meaningful in center-aligned mode.
  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } pwm_dir_e;

  // Number of cycles in one PWM period for a given mode and period value.
  // A zero period degenerates to a single-cycle period in both modes.
  function automatic int unsigned pwm_period_len(logic mode, int unsigned p);
    int unsigned len;
    if (p == 0) begin
      len = 1;
    end else if (mode == PWM_EDGE) begin
      len = p + 1;
    end else begin
      len = 2 * p;
    end
    return len;
  endfunction

endpackage

// File: rtl/pwm_ch.sv
// One PWM channel: double-buffered compare register and registered output.
// The active compare value is replaced from the shadow whenever the top level
// signals a period boundary (or while the generator is stopped).
module pwm_ch
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = PWM_CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 run,
  input  logic [CNT_WIDTH-1:0] cmp_shdw,
  input  logic [CNT_WIDTH-1:0] cnt,
  output logic                 pwm_out
);

  logic [CNT_WIDTH-1:0] cmp_q, cmp_d;
  logic                 out_q, out_d;

  // Next active compare value and next output sample.
  always_comb begin
    cmp_d = cmp_q;
    if (load) begin
      cmp_d = cmp_shdw;
    end
    // Compare uses the value active in this cycle, not the one being loaded.
    out_d = run & (cnt < cmp_q);
  end

  // Active compare register and output flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_q <= '0;
      out_q <= 1'b0;
    end else begin
      cmp_q <= cmp_d;
      out_q <= out_d;
    end
  end

  assign pwm_out = out_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator. A single period counter (edge- or
// center-aligned) is shared by all channels; period, mode and compare values
// are taken from shadow inputs only at a period boundary, so register writes
// never disturb the period in progress.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned CH_COUNT   = PWM_CH_COUNT_DEF,
  parameter int unsigned CNT_WIDTH  = PWM_CNT_WIDTH_DEF,
  parameter int unsigned PERIOD_RST = PWM_PERIOD_RST_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          mode_shdw,
  input  logic [CNT_WIDTH-1:0]          period_shdw,
  input  logic [CH_COUNT*CNT_WIDTH-1:0] cmp_shdw,
  output logic [CH_COUNT-1:0]           pwm_out,
  output logic                          period_strobe,
  output logic [CNT_WIDTH-1:0]          cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CntZero   = '0;
  localparam logic [CNT_WIDTH-1:0] CntOne    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] PeriodRst = CNT_WIDTH'(PERIOD_RST);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] p_act_q, p_act_d;
  logic                 mode_act_q, mode_act_d;
  logic                 strobe_q, strobe_d;
  pwm_dir_e             dir_q, dir_d;
  logic                 boundary;
  logic                 load;

  // Boundary decode: the cycle whose successor restarts the count at zero.
  always_comb begin
    boundary = 1'b0;
    if (p_act_q == CntZero) begin
      // Degenerate period: the counter sits at zero and every cycle ends one.
      boundary = 1'b1;
    end else if (mode_act_q == PWM_EDGE) begin
      boundary = (cnt_q == p_act_q);
    end else begin
      // Last down cycle; with a period of one there is no down phase, so the
      // single up step to 1 also closes the period.
      boundary = (cnt_q == CntOne) && ((dir_q == DirDown) || (p_act_q == CntOne));
    end
    // While stopped the shadows flow straight through into the active set.
    load = ~en | boundary;
  end

  // Counter and direction next state.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (load) begin
      cnt_d = CntZero;
      dir_d = DirUp;
    end else if (mode_act_q == PWM_EDGE) begin
      cnt_d = cnt_q + CntOne;
    end else begin
      unique case (dir_q)
        DirUp: begin
          if (cnt_q == p_act_q) begin
            dir_d = DirDown;
            cnt_d = cnt_q - CntOne;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        DirDown: cnt_d = cnt_q - CntOne;
        default: begin
          cnt_d = CntZero;
          dir_d = DirUp;
        end
      endcase
    end
  end

  // Active period/mode reload and the period-start strobe.
  always_comb begin
    p_act_d    = p_act_q;
    mode_act_d = mode_act_q;
    if (load) begin
      p_act_d    = period_shdw;
      mode_act_d = mode_shdw;
    end
    // Registered so it lines up with the first output sample of the period.
    strobe_d = en & (cnt_q == CntZero);
  end

  // Direction state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= DirUp;
    end else begin
      dir_q <= dir_d;
    end
  end

  // Counter, active period/mode and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= CntZero;
      p_act_q    <= PeriodRst;
      mode_act_q <= PWM_EDGE;
      strobe_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      p_act_q    <= p_act_d;
      mode_act_q <= mode_act_d;
      strobe_q   <= strobe_d;
    end
  end

  for (genvar i = 0; i < CH_COUNT; i++) begin : g_ch
    pwm_ch #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .run      (en),
      .cmp_shdw (cmp_shdw[i*CNT_WIDTH +: CNT_WIDTH]),
      .cnt      (cnt_q),
      .pwm_out  (pwm_out[i])
    );
  end

  assign period_strobe = strobe_q;
  assign cnt_o         = cnt_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: directed scenarios plus a randomized run,
// all compared against a period-position reference model.
module tb_pwm_multi;

  localparam int unsigned CH = 4;
  localparam int unsigned W  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            mode_shdw;
  logic [W-1:0]    period_shdw;
  logic [CH*W-1:0] cmp_shdw;
  logic [CH-1:0]   pwm_out;
  logic            period_strobe;
  logic [W-1:0]    cnt_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: position within the current period plus the active set.
  int            m_pos;
  int            m_p;
  int            m_mode;
  int            m_cmp [CH];
  logic [CH-1:0] m_pwm;
  logic          m_strobe;
  int            m_cnt;

  pwm_multi #(
    .CH_COUNT   (CH),
    .CNT_WIDTH  (W),
    .PERIOD_RST (255)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .mode_shdw     (mode_shdw),
    .period_shdw   (period_shdw),
    .cmp_shdw      (cmp_shdw),
    .pwm_out       (pwm_out),
    .period_strobe (period_strobe),
    .cnt_o         (cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish, want finish before 1000000");
    $fatal(1, "timeout");
  end

  function automatic int plen(int p, int mode);
    if (p == 0) return 1;
    if (mode == 0) return p + 1;
    return 2 * p;
  endfunction

  // Counter value at a given position of a period.
  function automatic int cnt_at(int pos, int p, int mode);
    if (p == 0) return 0;
    if (mode == 0) return pos;
    return (pos <= p) ? pos : 2 * p - pos;
  endfunction

  task automatic model_reset();
    m_pos    = 0;
    m_p      = 255;
    m_mode   = 0;
    for (int i = 0; i < CH; i++) m_cmp[i] = 0;
    m_pwm    = '0;
    m_strobe = 1'b0;
    m_cnt    = 0;
  endtask

  // Advance model and DUT by one clock; returns 1 time unit after the edge.
  task automatic tick();
    int cur;
    int len;
    cur = cnt_at(m_pos, m_p, m_mode);
    len = plen(m_p, m_mode);
    for (int i = 0; i < CH; i++) m_pwm[i] = en && (cur < m_cmp[i]);
    m_strobe = en && (cur == 0);
    if (!en || m_pos == len - 1) begin
      m_pos  = 0;
      m_p    = int'(period_shdw);
      m_mode = int'(mode_shdw);
      for (int i = 0; i < CH; i++) m_cmp[i] = int'(cmp_shdw[i*W +: W]);
    end else begin
      m_pos++;
    end
    m_cnt = cnt_at(m_pos, m_p, m_mode);
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmp(input int c0, input int c1, input int c2, input int c3);
    cmp_shdw = {W'(c3), W'(c2), W'(c1), W'(c0)};
  endtask

  // Stop, let the shadows load, then enable; next tick is the first cnt==0 cycle.
  task automatic start_run(input int p, input int mode);
    en          = 1'b0;
    period_shdw = W'(p);
    mode_shdw   = mode[0];
    tick();
    tick();
    en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    en = 1'b0; mode_shdw = 1'b0; period_shdw = '0; cmp_shdw = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({cnt_o, pwm_out, period_strobe} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got cnt=%0d pwm=%b stb=%b, want all zero",
               cnt_o, pwm_out, period_strobe);
    end
    en = 1'b1; period_shdw = 8'd9; set_cmp(4, 4, 4, 4);
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({cnt_o, pwm_out, period_strobe} !== '0) begin
      failures++;
      $display("FAIL reset_hold: got cnt=%0d pwm=%b stb=%b, want all zero",
               cnt_o, pwm_out, period_strobe);
    end
    rst_n = 1'b1;
    model_reset();
    for (int t = 1; t <= 20; t++) begin
      tick();
      checks++;
      if ({cnt_o, pwm_out, period_strobe} !== {W'(m_cnt), m_pwm, m_strobe}) begin
        failures++;
        $display("FAIL reset_model t=%0d: got cnt=%0d pwm=%b stb=%b, want cnt=%0d pwm=%b stb=%b",
                 t, cnt_o, pwm_out, period_strobe, m_cnt, m_pwm, m_strobe);
      end
    end
    // Period 255 and zero compares are active, not the shadows.
    checks++;
    if (cnt_o !== 8'd20 || pwm_out !== 4'b0000) begin
      failures++;
      $display("FAIL reset_active_vals: got cnt=%0d pwm=%b, want cnt=20 pwm=0000", cnt_o, pwm_out);
    end
  endtask

  task automatic test_edge_duty();
    int highs [CH];
    int strobes;
    int exp_highs [CH] = '{0, 9, 15, 30};
    strobes = 0;
    for (int i = 0; i < CH; i++) highs[i] = 0;
    set_cmp(0, 3, 5, 12);
    start_run(9, 0);
    for (int t = 1; t <= 30; t++) begin
      tick();
      for (int i = 0; i < CH; i++) highs[i] += int'(pwm_out[i]);
      strobes += int'(period_strobe);
      checks++;
      if ({cnt_o, pwm_out, period_strobe} !== {W'(m_cnt), m_pwm, m_strobe}) begin
        failures++;
        $display("FAIL edge_model t=%0d: got cnt=%0d pwm=%b stb=%b, want cnt=%0d pwm=%b stb=%b",
                 t, cnt_o, pwm_out, period_strobe, m_cnt, m_pwm, m_strobe);
      end
      checks++;
      if (period_strobe !== ((t - 1) % 10 == 0)) begin
        failures++;
        $display("FAIL edge_strobe t=%0d: got %b, want %b", t, period_strobe, ((t - 1) % 10 == 0));
      end
    end
    for (int i = 0; i < CH; i++) begin
      checks++;
      if (highs[i] != exp_highs[i]) begin
        failures++;
        $display("FAIL edge_duty ch%0d: got %0d high cycles, want %0d", i, highs[i], exp_highs[i]);
      end
    end
    checks++;
    if (strobes != 3) begin
      failures++;
      $display("FAIL edge_strobe_count: got %0d, want 3", strobes);
    end
  endtask

  task automatic test_center();
    int seq8 [8] = '{0, 1, 2, 3, 4, 3, 2, 1};
    int highs;
    int strobes;
    highs = 0; strobes = 0;
    set_cmp(2, 0, 5, 1);
    start_run(4, 1);
    for (int t = 1; t <= 32; t++) begin
      tick();
      highs   += int'(pwm_out[0]);
      strobes += int'(period_strobe);
      checks++;
      if ({cnt_o, pwm_out, period_strobe} !== {W'(m_cnt), m_pwm, m_strobe}) begin
        failures++;
        $display("FAIL center_model t=%0d: got cnt=%0d pwm=%b stb=%b, want cnt=%0d pwm=%b stb=%b",
                 t, cnt_o, pwm_out, period_strobe, m_cnt, m_pwm, m_strobe);
      end
      checks++;
      if (cnt_o !== W'(seq8[t % 8])) begin
        failures++;
        $display("FAIL center_seq t=%0d: got cnt=%0d, want %0d", t, cnt_o, seq8[t % 8]);
      end
    end
    checks++;
    if (highs != 12 || strobes != 4) begin
      failures++;
      $display("FAIL center_duty: got highs=%0d strobes=%0d, want highs=12 strobes=4",
               highs, strobes);
    end
  endtask

  task automatic test_shadow();
    int highs [5] = '{0, 0, 0, 0, 0};
    int exp_highs [5] = '{3, 7, 2, 2, 5};
    set_cmp(3, 0, 0, 0);
    start_run(9, 0);
    for (int t = 1; t <= 50; t++) begin
      if (t == 5)  set_cmp(7, 0, 0, 0);  // mid-period
      if (t == 20) set_cmp(2, 0, 0, 0);  // during the boundary cycle
      if (t == 31) set_cmp(5, 0, 0, 0);  // one cycle after the boundary
      tick();
      highs[(t - 1) / 10] += int'(pwm_out[0]);
      checks++;
      if ({cnt_o, pwm_out, period_strobe} !== {W'(m_cnt), m_pwm, m_strobe}) begin
        failures++;
        $display("FAIL shadow_model t=%0d: got cnt=%0d pwm=%b stb=%b, want cnt=%0d pwm=%b stb=%b",
                 t, cnt_o, pwm_out, period_strobe, m_cnt, m_pwm, m_strobe);
      end
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (highs[k] != exp_highs[k]) begin
        failures++;
        $display("FAIL shadow_period%0d: got %0d high cycles, want %0d", k, highs[k], exp_highs[k]);
      end
    end
  endtask

  task automatic test_mode_switch();
    int seq6 [6] = '{0, 1, 2, 3, 2, 1};
    logic exp_stb;
    set_cmp(2, 4, 0, 9);
    start_run(9, 0);
    for (int t = 1; t <= 24; t++) begin
      if (t == 5) begin
        mode_shdw   = 1'b1;
        period_shdw = 8'd3;
      end
      tick();
      exp_stb = (t == 1) || (t == 11) || (t == 17) || (t == 23);
      checks++;
      if (period_strobe !== exp_stb) begin
        failures++;
        $display("FAIL mode_strobe t=%0d: got %b, want %b", t, period_strobe, exp_stb);
      end
      checks++;
      if (t >= 10 && cnt_o !== W'(seq6[(t - 10) % 6])) begin
        failures++;
        $display("FAIL mode_seq t=%0d: got cnt=%0d, want %0d", t, cnt_o, seq6[(t - 10) % 6]);
      end
      checks++;
      if ({cnt_o, pwm_out, period_strobe} !== {W'(m_cnt), m_pwm, m_strobe}) begin
        failures++;
        $display("FAIL mode_model t=%0d: got cnt=%0d pwm=%b stb=%b, want cnt=%0d pwm=%b stb=%b",
                 t, cnt_o, pwm_out, period_strobe, m_cnt, m_pwm, m_strobe);
      end
    end
    mode_shdw = 1'b0;
  endtask

  task automatic test_enable_reset();
    set_cmp(8, 0, 3, 9);
    start_run(9, 0);
    for (int t = 1; t <= 5; t++) tick();
    checks++;
    if (cnt_o !== 8'd5) begin
      failures++;
      $display("FAIL en_pre_drop: got cnt=%0d, want 5", cnt_o);
    end
    en = 1'b0;
    tick();
    checks++;
    if ({cnt_o, pwm_out, period_strobe} !== '0) begin
      failures++;
      $display("FAIL en_drop: got cnt=%0d pwm=%b stb=%b, want all zero",
               cnt_o, pwm_out, period_strobe);
    end
    en = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      tick();
      checks++;
      if ({cnt_o, pwm_out, period_strobe} !== {W'(m_cnt), m_pwm, m_strobe}) begin
        failures++;
        $display("FAIL en_model t=%0d: got cnt=%0d pwm=%b stb=%b, want cnt=%0d pwm=%b stb=%b",
                 t, cnt_o, pwm_out, period_strobe, m_cnt, m_pwm, m_strobe);
      end
    end
    // Reset lands mid-cycle, well away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cnt_o, pwm_out, period_strobe} !== '0) begin
      failures++;
      $display("FAIL async_reset: got cnt=%0d pwm=%b stb=%b, want all zero",
               cnt_o, pwm_out, period_strobe);
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      checks++;
      if ({cnt_o, pwm_out, period_strobe} !== {W'(m_cnt), m_pwm, m_strobe}) begin
        failures++;
        $display("FAIL rst_model t=%0d: got cnt=%0d pwm=%b stb=%b, want cnt=%0d pwm=%b stb=%b",
                 t, cnt_o, pwm_out, period_strobe, m_cnt, m_pwm, m_strobe);
      end
    end
    checks++;
    if (cnt_o !== 8'd12) begin
      failures++;
      $display("FAIL rst_period: got cnt=%0d, want 12", cnt_o);
    end
  endtask

  task automatic test_corners();
    int highs [CH];
    int strobes;
    int max_cnt;
    set_cmp(0, 1, 200, 255);
    start_run(0, 0);
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if (cnt_o !== 8'd0 || pwm_out !== 4'b1110 || period_strobe !== 1'b1) begin
        failures++;
        $display("FAIL p0 t=%0d: got cnt=%0d pwm=%b stb=%b, want cnt=0 pwm=1110 stb=1",
                 t, cnt_o, pwm_out, period_strobe);
      end
    end
    for (int i = 0; i < CH; i++) highs[i] = 0;
    strobes = 0; max_cnt = 0;
    set_cmp(255, 0, 128, 255);
    start_run(255, 0);
    for (int t = 1; t <= 512; t++) begin
      tick();
      for (int i = 0; i < CH; i++) highs[i] += int'(pwm_out[i]);
      strobes += int'(period_strobe);
      if (int'(cnt_o) > max_cnt) max_cnt = int'(cnt_o);
      checks++;
      if ({cnt_o, pwm_out, period_strobe} !== {W'(m_cnt), m_pwm, m_strobe}) begin
        failures++;
        $display("FAIL p255_model t=%0d: got cnt=%0d pwm=%b stb=%b, want cnt=%0d pwm=%b stb=%b",
                 t, cnt_o, pwm_out, period_strobe, m_cnt, m_pwm, m_strobe);
      end
    end
    checks++;
    if (highs[0] != 510 || highs[1] != 0 || highs[2] != 256 || strobes != 2 || max_cnt != 255) begin
      failures++;
      $display("FAIL p255_duty: got h0=%0d h1=%0d h2=%0d stb=%0d max=%0d, want 510 0 256 2 255",
               highs[0], highs[1], highs[2], strobes, max_cnt);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 3000; t++) begin
      en = ($urandom_range(0, 99) >= 4);
      if ($urandom_range(0, 99) < 10) begin
        period_shdw = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255))
                                                  : W'($urandom_range(0, 12));
        mode_shdw   = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 99) < 15) begin
        for (int i = 0; i < CH; i++) begin
          cmp_shdw[i*W +: W] = ($urandom_range(0, 4) == 0) ? W'($urandom_range(0, 255))
                                                           : W'($urandom_range(0, 14));
        end
      end
      tick();
      checks++;
      if ({cnt_o, pwm_out, period_strobe} !== {W'(m_cnt), m_pwm, m_strobe}) begin
        failures++;
        $display("FAIL random_model t=%0d: got cnt=%0d pwm=%b stb=%b, want cnt=%0d pwm=%b stb=%b",
                 t, cnt_o, pwm_out, period_strobe, m_cnt, m_pwm, m_strobe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_edge_duty();
    test_center();
    test_shadow();
    test_mode_switch();
    test_enable_reset();
    test_corners();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator sharing one period counter across `CH_COUNT` outputs. Supports edge-aligned and center-aligned counting. Period, mode and per-channel compare values are double-buffered: they are written into shadow inputs at any time and take effect only at a period boundary. It sits between a control/register block that drives the shadows and the output pins (gate drivers, LEDs).

## Interface
- `CH_COUNT`, 4, number of PWM channels
- `CNT_WIDTH`, 8, width of the counter, period and compare values
- `PERIOD_RST`, 255, active period after reset
- `clk` in 1: single clock, all logic on the rising edge.
- `rst_n` in 1: reset, **asynchronous, active-low**.
- `en` in 1: run enable.
- `mode_shdw` in 1: shadow mode; 0 = edge-aligned, 1 = center-aligned.
- `period_shdw` in `CNT_WIDTH`: shadow period `P`.
- `cmp_shdw` in `CH_COUNT*CNT_WIDTH`: shadow compare values; channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
- `pwm_out` out `CH_COUNT`: registered PWM outputs.
- `period_strobe` out 1: one-cycle pulse in each cycle where `cnt == 0` while running.
- `cnt_o` out `CNT_WIDTH`: current counter value.

## Operation
- **Active registers:** `P_act`, `mode_act`, `cmp_act[i]`.
- **Boundary `B`:** the cycle whose next counter value is 0.
  - On `B`, all active registers load their shadows simultaneously.
  - The next cycle (`cnt == 0`) runs with the new values.
  - Mid-period shadow changes never affect the current period.
- **Edge mode:**
  - Count 0,1,…,`P_act`, then 0.
  - Period = `P_act+1` cycles; `B` is at `cnt == P_act`.
- **Center mode:**
  - Count up 0…`P_act`, then down `P_act-1`…1, then 0.
  - Period = `2*P_act` cycles; `B` is the last down cycle (`cnt == 1`).
  - For `P_act == 1`, `B` is at `cnt == 1`.
  - Direction flag resets to up at each boundary.
- **`P_act == 0` (either mode):** counter holds 0, every cycle is `B`, and shadows load every cycle.
- **Compare:** `pwm_out[i]` is registered `(cnt < cmp_act[i])`, unsigned, full width.
  - `cmp == 0` gives constant 0.
  - Edge mode: `cmp > P_act` gives constant 1; duty = `cmp/(P_act+1)`.
  - Center mode: output is symmetric about `cnt == P_act`.
- **Enable:**
  - While `en == 0`: `cnt = 0`, direction up, active registers load shadows every cycle, `pwm_out = 0`, `period_strobe = 0`.
  - First cycle with `en == 1`: `cnt == 0` using the values loaded in the previous cycle.
  - Dropping `en` mid-period aborts the period immediately; there is no completion.
- **Mode change:** takes effect only at `B`. The count always restarts at 0, so no direction glitch is possible.

## Timing
- **Reset values:** `cnt = 0`, direction up, `P_act = PERIOD_RST`, `mode_act = 0`, `cmp_act = 0`, `pwm_out = 0`, `period_strobe = 0`.
- **Reset mid-operation:** outputs go to reset values asynchronously.
- **`pwm_out` latency:** 1 cycle behind the counter value it compares.
- **`period_strobe`:** aligned with that same 1-cycle delay, i.e. it pulses in the same cycle as the first output sample of a new period.
- **Shadow sampling:** a shadow change visible at the clock edge ending cycle `B` is used in the next period; a change one cycle later waits a full period.
- **Counter widths:** no wrap beyond `CNT_WIDTH`. `P_act = 2^CNT_WIDTH-1` is legal; the counter never exceeds `P_act`.

## Structure
- **Shared package `pwm_pkg`:**
  - Mode constants `PWM_EDGE = 0`, `PWM_CENTER = 1`.
  - Default widths.
  - Helper function returning the period length in cycles for a given mode and `P`.
- **Sub-module `pwm_ch`**, one instance per channel via generate:
  - Active compare register with load on `B`.
  - Compare logic and output flop.
  - Ports: `clk`, `rst_n`, `load`, `run`, `cmp_shdw`, `cnt`, `pwm_out`.
- **Top level owns:** the counter, direction flag, `B` decode, `P_act`, `mode_act` and `period_strobe`.

## Test plan
- **Edge duty:** `P = 9`, `cmp = {0, 3, 5, 12}`, `en = 1`.
  - Period 10 cycles; outputs high 0/3/5/10 cycles per period.
  - `period_strobe` every 10 cycles.
- **Center mode:** `P = 4`, `cmp = 2`.
  - Count sequence 0,1,2,3,4,3,2,1,0…; period 8.
  - Output high at counts 0,1 (up) and 1 (down) → 3 cycles, centered on the zero point.
- **Shadow timing:** change `cmp` 3→7 mid-period at `P = 9`.
  - Current period stays at 3 high cycles; the next period gives 7.
  - Change written in cycle `B` takes effect next period; one cycle later it is delayed a full period.
- **Mode/period switch:** edge `P = 9` → center `P = 3` written mid-period.
  - Switch happens exactly after `cnt == 9`; the next period is 6 cycles.
- **Enable/reset:**
  - Drop `en` at `cnt == 5` → next cycle `cnt = 0` and `pwm_out = 0`.
  - Assert `rst_n = 0` asynchronously mid-period → outputs 0 before the next edge.
  - Release reset → `P_act = 255`.
- **Corners:**
  - `P = 0` → `pwm_out = 1` iff `cmp > 0`, and `cnt_o` stays 0.
  - `P = 255`, `cmp = 255` → high for 255 of 256 cycles, with no counter overflow.
